csa_pipe: RTL and testbench
===========================

CSA_PIPE -- requirements
Module: csa_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/sum width in bits; legal values 8..64.
REQ-002 SHALL have parameter BLOCK, default 8: carry-select block width; WIDTH SHALL be an integer multiple of BLOCK; STAGES = WIDTH/BLOCK.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operands a, b, cin are valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH  unsigned operand A.
REQ-008 SHALL have port b  input  WIDTH  unsigned operand B.
REQ-009 SHALL have port cin  input  1  carry-in.
REQ-010 SHALL have port out_valid  output  1  sum and cout are valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
REQ-013 SHALL have port cout  output  1  carry out of bit WIDTH-1.
REQ-014 SHALL have port ovf  output  1  signed overflow; present only under CSA_PIPE_OVF_EN.

Function
REQ-015 SHALL accept a transfer on an input handshake: in_valid=1 and in_ready=1 on a rising edge.
REQ-016 SHALL complete an output transfer on an output handshake: out_valid=1 and out_ready=1 on a rising edge.
REQ-017 SHALL implement STAGES pipeline stages; stage k resolves operand bits [k*BLOCK +: BLOCK].
REQ-018 SHALL in each stage precompute the block sum for carry-in 0 and for carry-in 1, then select one using the registered carry from stage k-1 (stage 0 uses cin).
REQ-019 SHALL carry the unresolved upper operand bits and the resolved lower sum bits forward with each stage register.
REQ-020 SHALL have a latency of exactly STAGES cycles from input handshake to out_valid=1 when not stalled.
REQ-021 SHALL sustain one result per cycle when out_ready is held at 1.
REQ-022 SHALL define advance = !out_valid || out_ready; all stage registers and valid bits SHALL update only when advance=1.
REQ-023 SHALL drive in_ready = advance, combinationally.
REQ-024 SHALL propagate in_valid=0 cycles through the pipeline as bubbles with their stage valid bit at 0.
REQ-025 SHALL hold sum, cout and out_valid stable while out_valid=1 and out_ready=0.
REQ-026 SHALL deliver results in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-027 SHALL produce sum wrap-around modulo 2^WIDTH with cout=1 when a+b+cin >= 2^WIDTH.
REQ-028 SHALL ignore a, b and cin when no input handshake occurs.

Reset
REQ-029 SHALL, while rst_n=0, force all stage valid bits and out_valid to 0 and sum and cout to 0, independent of clk.
REQ-030 SHALL discard all in-flight operands when reset asserts mid-operation; no result SHALL emerge after release.
REQ-031 SHALL drive in_ready=1 during reset and on the first cycle after release.

Configuration
REQ-032 SHALL, with macro CSA_PIPE_OVF_EN defined, provide port ovf = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), registered with the result; ovf SHALL have reset value 0, be held with sum during a stall and be valid only with out_valid.
REQ-033 SHALL, without CSA_PIPE_OVF_EN, omit port ovf and its logic; all other behaviour SHALL be identical.

Verification
REQ-034 SHALL cover WIDTH=8, BLOCK=4: a=25, b=37, cin=0 -> sum=62, cout=0, out_valid exactly 2 cycles after the handshake.
REQ-035 SHALL cover WIDTH=8, BLOCK=4: a=200, b=100, cin=0 -> sum=44, cout=1; with OVF_EN, ovf=0.
REQ-036 SHALL cover WIDTH=32, BLOCK=8: a=0xFFFFFFFF, b=0, cin=1 -> sum=0, cout=1 (carry ripples through all 4 stages); a=0x7FFFFFFF, b=1, cin=0 -> ovf=1.
REQ-037 SHALL cover streaming 100 random operand pairs with out_ready toggled randomly -> all results match the reference model, in order, with sum held stable while stalled.
REQ-038 SHALL cover rst_n asserted with 3 results in flight -> out_valid=0 immediately and no results appear afterwards; the first post-reset operands complete with the correct result.

Source files
------------

// File: rtl/csa_pipe_if.sv
// Handshake and operand/result bundle for csa_pipe.
// The ovf signal exists only when CSA_PIPE_OVF_EN is defined.
interface csa_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CSA_PIPE_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef CSA_PIPE_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef CSA_PIPE_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/csa_pipe.sv
// Pipelined carry-select adder: one BLOCK-wide slice resolved per stage, STAGES = WIDTH/BLOCK.
// Define CSA_PIPE_OVF_EN to add a registered signed-overflow flag (bus.ovf).
module csa_pipe #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input logic       clk,
  input logic       rst_n,
  csa_pipe_if.slave bus
);
  localparam int STAGES = WIDTH / BLOCK;

  logic advance;
  logic out_valid;

  // The whole pipe moves as one; it only freezes when a finished result is being refused.
  assign advance      = !out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IW = WIDTH - k * BLOCK;  // operand bits still unresolved on entry
    localparam int LW = (k + 1) * BLOCK;    // sum bits resolved on exit

    logic [IW-1:0]  a_src;
    logic [IW-1:0]  b_src;
    logic           c_src;
    logic           v_src;
    logic [BLOCK:0] blk_c0;
    logic [BLOCK:0] blk_c1;
    logic [BLOCK:0] blk_sel;
    logic [LW-1:0]  sum_d;
    logic [LW-1:0]  sum_q;
    logic           carry_q;
    logic           valid_q;

    if (k == 0) begin : g_head
      assign a_src = bus.a;
      assign b_src = bus.b;
      assign c_src = bus.cin;
      assign v_src = bus.in_valid;
      assign sum_d = blk_sel[BLOCK-1:0];
    end else begin : g_body
      assign a_src = g_stage[k-1].g_fwd.a_q;
      assign b_src = g_stage[k-1].g_fwd.b_q;
      assign c_src = g_stage[k-1].carry_q;
      assign v_src = g_stage[k-1].valid_q;
      assign sum_d = {blk_sel[BLOCK-1:0], g_stage[k-1].sum_q};
    end

    // Both block sums are formed in parallel; the incoming carry only drives the select.
    assign blk_c0  = {1'b0, a_src[BLOCK-1:0]} + {1'b0, b_src[BLOCK-1:0]};
    assign blk_c1  = {1'b0, a_src[BLOCK-1:0]} + {1'b0, b_src[BLOCK-1:0]} + (BLOCK+1)'(1);
    assign blk_sel = c_src ? blk_c1 : blk_c0;

    // NOTE: state uses non-blocking assignments so every stage samples its neighbour's
    // pre-edge value; data registers carry the async reset too, so sum/cout read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (advance) begin
        valid_q <= v_src;
        if (v_src) begin
          carry_q <= blk_sel[BLOCK];
          sum_q   <= sum_d;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [IW-BLOCK-1:0] a_q;
      logic [IW-BLOCK-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance && v_src) begin
          a_q <= a_src[IW-1:BLOCK];
          b_q <= b_src[IW-1:BLOCK];
        end
      end
    end else begin : g_tail
`ifdef CSA_PIPE_OVF_EN
      // The last block holds the operand MSBs, so overflow is decided here.
      logic ovf_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance && v_src) begin
          ovf_q <= (a_src[BLOCK-1] == b_src[BLOCK-1]) && (blk_sel[BLOCK-1] != a_src[BLOCK-1]);
        end
      end

      assign bus.ovf = ovf_q;
`endif
      assign out_valid     = valid_q;
      assign bus.out_valid = valid_q;
      assign bus.sum       = sum_q;
      assign bus.cout      = carry_q;
    end
  end
endmodule

// File: tb/tb_csa_pipe.sv
// Directed-vector and streaming bench for csa_pipe at 8/4 and 32/8 geometries.
// Define CSA_PIPE_OVF_EN to also check the overflow flag.
module tb_csa_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  csa_pipe_if #(.WIDTH(8))  if8 ();
  csa_pipe_if #(.WIDTH(32)) if32 ();

  csa_pipe #(.WIDTH(8), .BLOCK(4)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  csa_pipe #(.WIDTH(32), .BLOCK(8)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if32)
  );

  typedef struct {
    bit          narrow;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_in(input bit narrow, input logic v, input logic [31:0] a,
                          input logic [31:0] b, input logic c);
    if (narrow) begin
      if8.in_valid = v;
      if8.a        = a[7:0];
      if8.b        = b[7:0];
      if8.cin      = c;
    end else begin
      if32.in_valid = v;
      if32.a        = a;
      if32.b        = b;
      if32.cin      = c;
    end
  endtask

  task automatic read_out(input bit narrow, output logic ov, output logic [31:0] s,
                          output logic c, output logic o);
    o = 1'b0;
    if (narrow) begin
      ov = if8.out_valid;
      s  = 32'(if8.sum);
      c  = if8.cout;
`ifdef CSA_PIPE_OVF_EN
      o  = if8.ovf;
`endif
    end else begin
      ov = if32.out_valid;
      s  = if32.sum;
      c  = if32.cout;
`ifdef CSA_PIPE_OVF_EN
      o  = if32.ovf;
`endif
    end
  endtask

  // Entered and left at posedge+1 with the target pipe empty and out_ready=1.
  task automatic send_one(input vec_t v, input string tag);
    int          stages;
    int          lat;
    logic        ov;
    logic [31:0] s;
    logic        c;
    logic        o;
    stages = v.narrow ? 2 : 4;
    drive_in(v.narrow, 1'b1, v.a, v.b, v.cin);
    @(posedge clk); #1;
    // Inverted operands without in_valid must have no effect on the result.
    drive_in(v.narrow, 1'b0, ~v.a, ~v.b, ~v.cin);
    lat = 1;
    read_out(v.narrow, ov, s, c, o);
    while (!ov && lat < 12) begin
      @(posedge clk); #1;
      lat++;
      read_out(v.narrow, ov, s, c, o);
    end
    check({tag, " latency"}, 64'(lat), 64'(stages));
    check({tag, " sum"}, 64'(s), 64'(v.sum));
    check({tag, " cout"}, 64'(c), 64'(v.cout));
`ifdef CSA_PIPE_OVF_EN
    check({tag, " ovf"}, 64'(o), 64'(v.ovf));
`endif
    @(posedge clk); #1;
    read_out(v.narrow, ov, s, c, o);
    check({tag, " out_valid drops"}, 64'(ov), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[14];
    logic [32:0] expq[$];
    logic [32:0] e;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic [31:0] held_sum;
    logic        held_cout;
    bit          stalled;
    int          sent;
    int          recv;
    int          cyc;
    int          seen;
    vec_t        post;

    vecs[0]  = '{1'b1, 32'd25,         32'd37,         1'b0, 32'd62,         1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'd200,        32'd100,        1'b0, 32'd44,         1'b1, 1'b0};
    vecs[2]  = '{1'b1, 32'd255,        32'd0,          1'b1, 32'd0,          1'b1, 1'b0};
    vecs[3]  = '{1'b1, 32'd127,        32'd1,          1'b0, 32'd128,        1'b0, 1'b1};
    vecs[4]  = '{1'b1, 32'd128,        32'd128,        1'b0, 32'd0,          1'b1, 1'b1};
    vecs[5]  = '{1'b1, 32'h0F,         32'h01,         1'b0, 32'h10,         1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'd0,          32'd0,          1'b0, 32'd0,          1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'h0F,         32'hF0,         1'b1, 32'h00,         1'b1, 1'b0};
    vecs[8]  = '{1'b0, 32'hFFFF_FFFF,  32'h0,          1'b1, 32'h0,          1'b1, 1'b0};
    vecs[9]  = '{1'b0, 32'h7FFF_FFFF,  32'h1,          1'b0, 32'h8000_0000,  1'b0, 1'b1};
    vecs[10] = '{1'b0, 32'h1234_5678,  32'h0FED_CBA8,  1'b0, 32'h2222_2220,  1'b0, 1'b0};
    vecs[11] = '{1'b0, 32'h8000_0000,  32'h8000_0000,  1'b1, 32'h0000_0001,  1'b1, 1'b1};
    vecs[12] = '{1'b0, 32'h0000_00FF,  32'h0000_0001,  1'b0, 32'h0000_0100,  1'b0, 1'b0};
    vecs[13] = '{1'b0, 32'hDEAD_BEEF,  32'h2152_4110,  1'b1, 32'h0,          1'b1, 1'b0};

    drive_in(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    drive_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    if8.out_ready  = 1'b1;
    if32.out_ready = 1'b1;

    // Reset state, before any clock edge and again after a few edges.
    #2;
    check("reset out_valid8", 64'(if8.out_valid), 64'(0));
    check("reset sum8", 64'(if8.sum), 64'(0));
    check("reset out_valid32", 64'(if32.out_valid), 64'(0));
    check("reset cout32", 64'(if32.cout), 64'(0));
    check("reset in_ready32", 64'(if32.in_ready), 64'(1));
    repeat (3) @(posedge clk);
    check("reset sum32 clocked", 64'(if32.sum), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    check("in_ready after release", 64'(if8.in_ready), 64'(1));
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      send_one(vecs[i], $sformatf("vec%0d", i));
    end

    // Streaming with random backpressure and input gaps against a + b + cin model.
    sent = 0;
    recv = 0;
    cyc = 0;
    stalled = 1'b0;
    held_sum = '0;
    held_cout = 1'b0;
    while (recv < 100 && cyc < 4000) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1));
      drive_in(1'b0, (sent < 100) && ($urandom_range(3) != 0), ra, rb, rc);
      if32.out_ready = 1'($urandom_range(1));
      @(negedge clk);
      if (if32.in_valid && if32.in_ready) begin
        expq.push_back({1'b0, ra} + {1'b0, rb} + 33'(rc));
        sent++;
      end
      if (stalled) begin
        check("stall out_valid held", 64'(if32.out_valid), 64'(1));
        check("stall sum held", 64'(if32.sum), 64'(held_sum));
        check("stall cout held", 64'(if32.cout), 64'(held_cout));
      end
      stalled = 1'b0;
      if (if32.out_valid) begin
        if (if32.out_ready) begin
          check("stream result expected", 64'(expq.size() > 0), 64'(1));
          if (expq.size() > 0) begin
            e = expq.pop_front();
            check($sformatf("stream%0d sum", recv), 64'(if32.sum), 64'(e[31:0]));
            check($sformatf("stream%0d cout", recv), 64'(if32.cout), 64'(e[32]));
          end
          recv++;
        end else begin
          stalled   = 1'b1;
          held_sum  = if32.sum;
          held_cout = if32.cout;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("stream results received", 64'(recv), 64'(100));
    check("stream queue drained", 64'(expq.size()), 64'(0));
    drive_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    if32.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Reset with three results in flight, the oldest already stalled at the output.
    if32.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_in(1'b0, 1'b1, 32'h1000_0000 * (i + 1), 32'h0000_0101, 1'b1);
      @(posedge clk); #1;
    end
    drive_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    check("pre-reset out_valid", 64'(if32.out_valid), 64'(1));
    check("pre-reset sum", 64'(if32.sum), 64'(32'h1000_0102));
    check("stalled in_ready low", 64'(if32.in_ready), 64'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-reset out_valid", 64'(if32.out_valid), 64'(0));
    check("mid-reset sum", 64'(if32.sum), 64'(0));
    check("mid-reset cout", 64'(if32.cout), 64'(0));
    check("mid-reset in_ready", 64'(if32.in_ready), 64'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("post-release in_ready", 64'(if32.in_ready), 64'(1));
    if32.out_ready = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (if32.out_valid) seen++;
    end
    check("no result after reset", 64'(seen), 64'(0));

    post = '{1'b0, 32'hCAFE_F00D, 32'h3501_0FF3, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    send_one(post, "post-reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
